// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter over eight edge-triggered requesters with a one-hot,
// valid/ready grant output and a sticky pending-request register.
module rr_onehot_arbiter #(
    parameter int PRIO_START = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic       gnt_valid_o,
    input  logic       gnt_ready_i,
    output logic [7:0] pending_o,
    output logic       ovf_o
);

    localparam logic [2:0] PTR_RST = 3'(PRIO_START);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q, req_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] gidx_q, gidx_d;
    logic       ovf_q, ovf_d;

    logic [7:0] req_edge;
    logic [7:0] clr;
    logic       hs;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] scan_idx;

    always_comb begin
        req_edge  = req_i & ~req_q;
        hs        = (state_q == GRANT) && gnt_ready_i;
        clr       = hs ? gnt_q : 8'h00;
        req_d     = req_i;
        // A new edge on the bit being granted re-arms it rather than overflowing.
        pending_d = (pending_q & ~clr) | req_edge;
        ovf_d     = |(req_edge & pending_q & ~clr);

        pick_found = 1'b0;
        pick_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!pick_found && pending_q[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end

        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = 8'h01 << pick_idx;
                    gidx_d  = pick_idx;
                end
            end
            GRANT: begin
                if (hs) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    ptr_d   = gidx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 8'h00;
            pending_q <= 8'h00;
            gnt_q     <= 8'h00;
            ptr_q     <= PTR_RST;
            gidx_q    <= 3'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == GRANT);
    assign pending_o   = pending_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: reset, single grant, wrap, backpressure,
// overflow/simultaneous edge, and asynchronous reset during a grant.
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_i = 8'h00;
    logic [7:0] gnt_o;
    logic       gnt_valid_o;
    logic       gnt_ready_i = 1'b0;
    logic [7:0] pending_o;
    logic       ovf_o;

    int n_cmp = 0;
    int n_bad = 0;

    rr_onehot_arbiter #(.PRIO_START(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o),
        .gnt_valid_o(gnt_valid_o), .gnt_ready_i(gnt_ready_i),
        .pending_o(pending_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_i = 8'h00;
        gnt_ready_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_i = 8'hFF;
        gnt_ready_i = 1'b1;
        step();
        n_cmp++; if (gnt_o !== 8'h00) begin n_bad++; $display("FAIL reset_gnt: got %h want 00", gnt_o); end
        n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", gnt_valid_o); end
        n_cmp++; if (pending_o !== 8'h00) begin n_bad++; $display("FAIL reset_pending: got %h want 00", pending_o); end
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        gnt_ready_i = 1'b1;
        req_i = 8'h10;
        step();
        n_cmp++; if (pending_o !== 8'h10) begin n_bad++; $display("FAIL single_pend: got %h want 10", pending_o); end
        n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", gnt_valid_o); end
        req_i = 8'h00;
        step();
        n_cmp++; if (gnt_o !== 8'h10) begin n_bad++; $display("FAIL single_gnt: got %h want 10", gnt_o); end
        n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", gnt_valid_o); end
        n_cmp++; if (pending_o !== 8'h10) begin n_bad++; $display("FAIL single_pend_held: got %h want 10", pending_o); end
        step();
        n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_drop: got %b want 0", gnt_valid_o); end
        n_cmp++; if (pending_o !== 8'h00) begin n_bad++; $display("FAIL single_clr: got %h want 00", pending_o); end
        // ptr is now 5: 0x21 must grant bit 5 before bit 0.
        req_i = 8'h21;
        step();
        req_i = 8'h00;
        step();
        n_cmp++; if (gnt_o !== 8'h20) begin n_bad++; $display("FAIL single_ptr5: got %h want 20", gnt_o); end
        step();
        step();
        n_cmp++; if (gnt_o !== 8'h01) begin n_bad++; $display("FAIL single_next: got %h want 01", gnt_o); end
        step();
    endtask

    task automatic test_wrap();
        apply_reset();
        gnt_ready_i = 1'b1;
        req_i = 8'h81;
        step();
        req_i = 8'h00;
        step();
        n_cmp++; if (gnt_o !== 8'h01) begin n_bad++; $display("FAIL wrap_first: got %h want 01", gnt_o); end
        step();
        n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL wrap_idle: got %b want 0", gnt_valid_o); end
        n_cmp++; if (pending_o !== 8'h80) begin n_bad++; $display("FAIL wrap_pend: got %h want 80", pending_o); end
        step();
        n_cmp++; if (gnt_o !== 8'h80) begin n_bad++; $display("FAIL wrap_second: got %h want 80", gnt_o); end
        n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL wrap_valid2: got %b want 1", gnt_valid_o); end
        step();
        n_cmp++; if (pending_o !== 8'h00) begin n_bad++; $display("FAIL wrap_done: got %h want 00", pending_o); end
        // ptr back at 0: 0x81 must grant bit 0 first.
        req_i = 8'h81;
        step();
        req_i = 8'h00;
        step();
        n_cmp++; if (gnt_o !== 8'h01) begin n_bad++; $display("FAIL wrap_ptr0: got %h want 01", gnt_o); end
        step();
        step();
        step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        gnt_ready_i = 1'b0;
        req_i = 8'h04;
        step();
        req_i = 8'h00;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req_i = 8'h02;
            if (i == 2) req_i = 8'h00;
            step();
            n_cmp++; if (gnt_o !== 8'h04) begin n_bad++; $display("FAIL bp_gnt[%0d]: got %h want 04", i, gnt_o); end
            n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, gnt_valid_o); end
        end
        n_cmp++; if (pending_o !== 8'h06) begin n_bad++; $display("FAIL bp_pend: got %h want 06", pending_o); end
        gnt_ready_i = 1'b1;
        step();
        n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_hs: got %b want 0", gnt_valid_o); end
        n_cmp++; if (pending_o !== 8'h02) begin n_bad++; $display("FAIL bp_pend2: got %h want 02", pending_o); end
        step();
        n_cmp++; if (gnt_o !== 8'h02) begin n_bad++; $display("FAIL bp_next: got %h want 02", gnt_o); end
        step();
    endtask

    task automatic test_overflow();
        apply_reset();
        gnt_ready_i = 1'b0;
        req_i = 8'h04;
        step();
        req_i = 8'h00;
        step();
        req_i = 8'h08;
        step();
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL ovf_fresh: got %b want 0", ovf_o); end
        n_cmp++; if (pending_o !== 8'h0C) begin n_bad++; $display("FAIL ovf_pend: got %h want 0c", pending_o); end
        req_i = 8'h00;
        step();
        req_i = 8'h08;
        step();
        n_cmp++; if (ovf_o !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", ovf_o); end
        req_i = 8'h00;
        step();
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL ovf_one_cycle: got %b want 0", ovf_o); end
        n_cmp++; if (gnt_o !== 8'h04) begin n_bad++; $display("FAIL ovf_gnt_held: got %h want 04", gnt_o); end
        gnt_ready_i = 1'b1;
        step();
        gnt_ready_i = 1'b0;
        step();
        n_cmp++; if (gnt_o !== 8'h08) begin n_bad++; $display("FAIL ovf_gnt3: got %h want 08", gnt_o); end
        // New edge on bit 3 in the very cycle its grant is accepted.
        req_i = 8'h08;
        gnt_ready_i = 1'b1;
        step();
        n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL sim_no_ovf: got %b want 0", ovf_o); end
        n_cmp++; if (pending_o !== 8'h08) begin n_bad++; $display("FAIL sim_pend: got %h want 08", pending_o); end
        n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL sim_hs: got %b want 0", gnt_valid_o); end
        req_i = 8'h00;
        step();
        n_cmp++; if (gnt_o !== 8'h08) begin n_bad++; $display("FAIL sim_regrant: got %h want 08", gnt_o); end
        step();
        n_cmp++; if (pending_o !== 8'h00) begin n_bad++; $display("FAIL sim_done: got %h want 00", pending_o); end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        gnt_ready_i = 1'b0;
        req_i = 8'h01;
        step();
        req_i = 8'h00;
        step();
        n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid: got %b want 1", gnt_valid_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid: got %b want 0", gnt_valid_o); end
        n_cmp++; if (gnt_o !== 8'h00) begin n_bad++; $display("FAIL rst_async_gnt: got %h want 00", gnt_o); end
        n_cmp++; if (pending_o !== 8'h00) begin n_bad++; $display("FAIL rst_async_pend: got %h want 00", pending_o); end
        step();
        rst_n = 1'b1;
        gnt_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_no_grant[%0d]: got %b want 0", i, gnt_valid_o); end
        end
        // A request already high when reset releases counts as a rising edge.
        rst_n = 1'b0;
        req_i = 8'h20;
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (pending_o !== 8'h20) begin n_bad++; $display("FAIL rel_edge_pend: got %h want 20", pending_o); end
        step();
        n_cmp++; if (gnt_o !== 8'h20) begin n_bad++; $display("FAIL rel_edge_gnt: got %h want 20", gnt_o); end
        step();
        n_cmp++; if (pending_o !== 8'h00) begin n_bad++; $display("FAIL rel_edge_done: got %h want 00", pending_o); end
        req_i = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_overflow();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 The block SHALL expose parameter PRIO_START, default 0, the round-robin pointer value (0..7) loaded at reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port req_i, input, 8 bits, raw request lines (bit k = requester k), synchronous to clk.
REQ-005 The block SHALL have port gnt_o, output, 8 bits, the one-hot grant vector that feeds the 8-to-3 encoder stage.
REQ-006 The block SHALL have port gnt_valid_o, output, 1 bit, high when gnt_o holds a valid grant.
REQ-007 The block SHALL have port gnt_ready_i, input, 1 bit, downstream acceptance of the current grant.
REQ-008 The block SHALL have port pending_o, output, 8 bits, the current pending-request register.
REQ-009 The block SHALL have port ovf_o, output, 1 bit, a one-cycle pulse for a request edge lost to an already-pending bit.

Function
REQ-010 The block SHALL register req_i into req_q each cycle and form edge = req_i & ~req_q; only rising edges create requests.
REQ-011 pending SHALL update as pending_next = (pending & ~clr) | edge, where clr is the one-hot grant on a handshake cycle and 0 otherwise; set wins over clear on the same bit.
REQ-012 A handshake SHALL occur on a rising clk edge where gnt_valid_o = 1 and gnt_ready_i = 1.
REQ-013 The FSM SHALL have two states: IDLE (gnt_valid_o = 0, gnt_o = 8'h00) and GRANT (gnt_valid_o = 1, gnt_o exactly one bit set).
REQ-014 IDLE->GRANT SHALL occur when the registered pending != 0; gnt_o loads the first set pending bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
REQ-015 GRANT SHALL hold gnt_o and gnt_valid_o stable until handshake; GRANT->IDLE on handshake, no other exit except reset.
REQ-016 On handshake with granted index g, ptr SHALL become (g+1) mod 8 (wrap 7->0).
REQ-017 Latency SHALL be: req_i rise sampled at edge t0 -> pending bit visible after t0 -> gnt_valid_o high after edge t1.
REQ-018 Back-to-back grants SHALL be separated by exactly one IDLE cycle; peak throughput is one grant per 2 cycles.
REQ-019 Requests arriving while in GRANT SHALL NOT change gnt_o; they are considered at the next IDLE evaluation.
REQ-020 ovf_o SHALL pulse for one cycle when edge[k] = 1 and pending[k] = 1 and bit k is not being cleared that cycle; the edge is absorbed.
REQ-021 gnt_ready_i SHALL be ignored in IDLE.
REQ-022 pending_o SHALL equal the pending register; the granted bit stays set in pending_o until the handshake cycle.

Reset
REQ-023 While rst_n = 0, the block SHALL hold req_q = 0, pending = 0, ptr = PRIO_START, state = IDLE, gnt_o = 0, gnt_valid_o = 0, ovf_o = 0, independent of clk.
REQ-024 A reset assertion in GRANT SHALL drop the grant immediately without a handshake; pending requests are discarded.
REQ-025 Because req_q resets to 0, a req_i bit already high at the first edge after reset release SHALL register as a rising edge.

Verification
REQ-026 Single request: PRIO_START=0, pulse req_i=8'h10 for 1 cycle, ready=1 -> gnt_o=8'h10 with gnt_valid_o high 2 edges later for one cycle, then ptr=5 and pending_o=0.
REQ-027 Round-robin wrap: req_i 0->8'h81 in one cycle, ready=1 -> grants 8'h01 then 8'h80 with one IDLE cycle between; ptr ends at 0.
REQ-028 Backpressure: grant 8'h04 with ready=0 for 5 cycles -> gnt_o/gnt_valid_o constant; new edge on bit 1 does not alter gnt_o; after ready=1, the next grant is 8'h02 (bit 1).
REQ-029 Overflow/simultaneous: bit 3 pending, not granted, new edge on bit 3 -> ovf_o=1 for one cycle; edge on bit 3 in its own handshake cycle -> no ovf_o, bit 3 stays pending and is re-granted.
REQ-030 Reset mid-grant: assert rst_n=0 asynchronously while gnt_valid_o=1 -> gnt_valid_o, gnt_o, pending_o go 0 before the next clk edge; after release, no grant until a new rising req edge.
